// File: rtl/atomic_access_ctrl_if.sv
// Bus bundle between the datapath/dcache/link-module environment and
// atomic_access_ctrl.
//   slave  : the controller's view (requests, cache and link verdict in;
//            dhit/dmemload, cache access, link controls and stats out)
//   master : the environment's view (datapath, dcache and link module)
interface atomic_access_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  // datapath request / response
  logic              dmemREN;
  logic              dmemWEN;
  logic              datomic;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;
  // dcache port
  logic              c_ren;
  logic              c_wen;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_store;
  logic              c_hit;
  logic [WORD_W-1:0] c_load;
  // link module
  logic [WORD_W-1:0] lm_addr_cpu;
  logic              lm_update;
  logic              lm_invalid_cpu;
  logic              lm_write_valid;
  // SC statistics
  logic [CNT_W-1:0]  sc_ok_cnt;
  logic [CNT_W-1:0]  sc_fail_cnt;

  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
    input  c_hit, c_load, lm_write_valid,
    output dhit, dmemload, c_ren, c_wen, c_addr, c_store,
    output lm_addr_cpu, lm_update, lm_invalid_cpu, sc_ok_cnt, sc_fail_cnt
  );

  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
    output c_hit, c_load, lm_write_valid,
    input  dhit, dmemload, c_ren, c_wen, c_addr, c_store,
    input  lm_addr_cpu, lm_update, lm_invalid_cpu, sc_ok_cnt, sc_fail_cnt
  );
endinterface

// File: rtl/atomic_access_ctrl.sv
// atomic_access_ctrl: sequences LL/SC accesses between the datapath dcache
// request port and the dcache, driving the link module (addr_cpu, update,
// invalid_cpu) and consuming its write_valid verdict. Plain loads/stores pass
// straight through. Keeps saturating SC success/fail counters.
// Ports:
//   CLK  : clock, rising edge
//   nRST : synchronous active-low reset; forces every output to 0 while low
//   bus  : atomic_access_ctrl_if.slave (datapath, dcache, link module, stats)
module atomic_access_ctrl #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                 CLK,
  input logic                 nRST,
  atomic_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LL_RD, SC_CHK, SC_WR, SC_FAIL} state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] req_addr, req_data;
  logic [CNT_W-1:0]  ok_cnt, fail_cnt;
  logic              capture;
  logic              sc_ok, sc_fail;

  // An atomic request is latched in IDLE; the cache is not touched that cycle.
  assign capture = (state == IDLE) && bus.datomic && (bus.dmemREN || bus.dmemWEN);

  // state register + request capture
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      req_addr <= '0;
      req_data <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        req_addr <= bus.dmemaddr;
        req_data <= bus.dmemstore;
      end
    end
  end

  // saturating SC statistics
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ok_cnt   <= '0;
      fail_cnt <= '0;
    end else begin
      if (sc_ok && ok_cnt != '1)     ok_cnt   <= ok_cnt + 1'b1;
      if (sc_fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
    end
  end

  // next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (capture) state_n = bus.dmemREN ? LL_RD : SC_CHK; // REN wins: LL
      LL_RD:   if (bus.c_hit) state_n = IDLE;
      SC_CHK:  state_n = bus.lm_write_valid ? SC_WR : SC_FAIL;
      // A hit means the write already committed, even if the link dropped
      // in the same cycle.
      SC_WR:   if (bus.c_hit) state_n = IDLE;
               else if (!bus.lm_write_valid) state_n = SC_FAIL;
      SC_FAIL: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.dhit           = 1'b0;
    bus.dmemload       = '0;
    bus.c_ren          = 1'b0;
    bus.c_wen          = 1'b0;
    bus.c_addr         = '0;
    bus.c_store        = '0;
    bus.lm_addr_cpu    = '0;
    bus.lm_update      = 1'b0;
    bus.lm_invalid_cpu = 1'b0;
    bus.sc_ok_cnt      = '0;
    bus.sc_fail_cnt    = '0;
    sc_ok              = 1'b0;
    sc_fail            = 1'b0;
    if (nRST) begin
      bus.lm_addr_cpu = req_addr;
      bus.sc_ok_cnt   = ok_cnt;
      bus.sc_fail_cnt = fail_cnt;
      case (state)
        IDLE: begin
          if (!bus.datomic) begin
            bus.c_ren    = bus.dmemREN;
            bus.c_wen    = bus.dmemWEN;
            bus.c_addr   = bus.dmemaddr;
            bus.c_store  = bus.dmemstore;
            bus.dhit     = bus.c_hit;
            bus.dmemload = bus.c_load;
          end
        end
        LL_RD: begin
          bus.c_ren  = 1'b1;
          bus.c_addr = req_addr;
          if (bus.c_hit) begin
            bus.dhit      = 1'b1;
            bus.dmemload  = bus.c_load;
            bus.lm_update = 1'b1;
          end
        end
        SC_WR: begin
          bus.c_wen   = 1'b1;
          bus.c_addr  = req_addr;
          bus.c_store = req_data;
          if (bus.c_hit) begin
            bus.dhit           = 1'b1;
            bus.dmemload       = {{(WORD_W-1){1'b0}}, 1'b1};
            bus.lm_invalid_cpu = 1'b1;
            sc_ok              = 1'b1;
          end
        end
        SC_FAIL: begin
          bus.dhit           = 1'b1;
          bus.lm_invalid_cpu = 1'b1;
          sc_fail            = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
